amp_result_reader: RTL and testbench

AMP_RESULT_READER -- requirements
Module: amp_result_reader

---
 rtl/amp_result_reader.sv | 145 ++++++++++++++
 tb/tb_amp_result_reader.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/amp_result_reader.sv
// Amplifier result reader: FWFT FIFO of {seq no, product, scaler} with an
// in-line sequence/range checker and sticky, clearable error reporting.
module amp_result_reader #(
   parameter int RD_DATA_WIDTH = 32,
   parameter int SCALER_WIDTH  = 16,
   parameter int DEPTH         = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       rd_val_i,
   input  logic [RD_DATA_WIDTH-1:0]   rd_data_i,
   input  logic [SCALER_WIDTH-1:0]    scaler_i,
   input  logic                       out_ready_i,
   input  logic                       clr_err_i,
   output logic                       out_valid_o,
   output logic [7:0]                 out_no_o,
   output logic [23:0]                out_result_o,
   output logic [SCALER_WIDTH-1:0]    out_scaler_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic                       overflow_o,
   output logic                       seq_err_o,
   output logic [7:0]                 err_cnt_o,
   output logic                       chk_state_o
);

   localparam int AW    = $clog2(DEPTH);
   localparam int EW    = 8 + 24 + SCALER_WIDTH;
   localparam int LIM_W = (SCALER_WIDTH + 8 > 24) ? SCALER_WIDTH + 8 : 24;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   // Handshake: a pop happens on any edge where out_valid_o && out_ready_i;
   // rd_val_i is a single-cycle qualifier with no backpressure.
   typedef enum logic {SYNC = 1'b0, TRACK = 1'b1} state_t;

   logic [EW-1:0]  mem_q [DEPTH];
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [AW:0]    count_q, count_d;
   state_t         state_q, state_d;
   logic [7:0]     exp_no_q, exp_no_d;
   logic           overflow_q, overflow_d;
   logic           seq_err_q, seq_err_d;
   logic [7:0]     err_cnt_q, err_cnt_d;

   logic           pop, push;
   logic [7:0]     rd_no;
   logic [23:0]    rd_prod;
   logic [LIM_W-1:0] limit;
   logic           range_err, seq_mis, sample_err;
   logic [EW-1:0]  head;

   assign rd_no   = rd_data_i[31:24];
   assign rd_prod = rd_data_i[23:0];

   always_comb begin
      pop        = (count_q != '0) && out_ready_i;
      push       = rd_val_i && ((count_q != FULL_CNT) || pop);
      limit      = (LIM_W'(scaler_i) << 8) - LIM_W'(scaler_i);
      range_err  = LIM_W'(rd_prod) > limit;
      seq_mis    = (state_q == TRACK) && (rd_no != exp_no_q);
      sample_err = rd_val_i && (range_err || seq_mis);
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + (AW+1)'(1);
      else if (pop && !push) count_d = count_q - (AW+1)'(1);
   end

   // Checker next-state; clear wins over anything observed in the same cycle.
   always_comb begin
      state_d    = state_q;
      exp_no_d   = exp_no_q;
      overflow_d = overflow_q;
      seq_err_d  = seq_err_q;
      err_cnt_d  = err_cnt_q;
      if (clr_err_i) begin
         state_d    = SYNC;
         overflow_d = 1'b0;
         seq_err_d  = 1'b0;
         err_cnt_d  = 8'd0;
      end else begin
         if (rd_val_i) begin
            state_d  = TRACK;
            exp_no_d = rd_no + 8'd1;
         end
         if (rd_val_i && !push) overflow_d = 1'b1;
         if (sample_err) begin
            seq_err_d = 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         state_q    <= SYNC;
         exp_no_q   <= 8'd0;
         overflow_q <= 1'b0;
         seq_err_q  <= 1'b0;
         err_cnt_q  <= 8'd0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         state_q    <= state_d;
         exp_no_q   <= exp_no_d;
         overflow_q <= overflow_d;
         seq_err_q  <= seq_err_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   // Storage is reset so the head reads as zero right after reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (push) begin
         mem_q[wr_ptr_q] <= {rd_no, rd_prod, scaler_i};
      end
   end

   assign head         = mem_q[rd_ptr_q];
   assign out_no_o     = head[EW-1 -: 8];
   assign out_result_o = head[SCALER_WIDTH +: 24];
   assign out_scaler_o = head[SCALER_WIDTH-1:0];
   assign out_valid_o  = (count_q != '0);
   assign empty_o      = (count_q == '0);
   assign full_o       = (count_q == FULL_CNT);
   assign count_o      = count_q;
   assign overflow_o   = overflow_q;
   assign seq_err_o    = seq_err_q;
   assign err_cnt_o    = err_cnt_q;
   assign chk_state_o  = (state_q == TRACK);

endmodule

// File: tb/tb_amp_result_reader.sv
// Randomized + directed bench for amp_result_reader with a queue-based
// reference model and a decoupled pop monitor.
module tb_amp_result_reader;

   localparam int DEPTH = 4;
   localparam int SW    = 16;
   localparam int EW    = 8 + 24 + SW;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic          rd_val_i = 1'b0;
   logic [31:0]   rd_data_i = '0;
   logic [SW-1:0] scaler_i = '0;
   logic          out_ready_i = 1'b0;
   logic          clr_err_i = 1'b0;
   logic          out_valid_o;
   logic [7:0]    out_no_o;
   logic [23:0]   out_result_o;
   logic [SW-1:0] out_scaler_o;
   logic [2:0]    count_o;
   logic          full_o, empty_o, overflow_o, seq_err_o;
   logic [7:0]    err_cnt_o;
   logic          chk_state_o;

   amp_result_reader #(.RD_DATA_WIDTH(32), .SCALER_WIDTH(SW), .DEPTH(DEPTH)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .rd_val_i(rd_val_i), .rd_data_i(rd_data_i),
      .scaler_i(scaler_i), .out_ready_i(out_ready_i), .clr_err_i(clr_err_i),
      .out_valid_o(out_valid_o), .out_no_o(out_no_o), .out_result_o(out_result_o),
      .out_scaler_o(out_scaler_o), .count_o(count_o), .full_o(full_o),
      .empty_o(empty_o), .overflow_o(overflow_o), .seq_err_o(seq_err_o),
      .err_cnt_o(err_cnt_o), .chk_state_o(chk_state_o)
   );

   always #5 clk_i = ~clk_i;

   int total = 0;
   int bad   = 0;
   logic [EW-1:0] exp_q[$];

   // Reference model: occupancy, checker sync flag, expected number, error state
   int m_cnt   = 0;
   bit m_track = 0;
   int m_exp   = 0;
   int m_errs  = 0;
   bit m_ovf   = 0;
   bit m_serr  = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_status();
      chk("count", count_o, m_cnt);
      chk("empty", empty_o, m_cnt == 0);
      chk("full", full_o, m_cnt == DEPTH);
      chk("out_valid", out_valid_o, m_cnt != 0);
      chk("overflow", overflow_o, m_ovf);
      chk("seq_err", seq_err_o, m_serr);
      chk("err_cnt", err_cnt_o, m_errs);
      chk("chk_state", chk_state_o, m_track);
   endtask

   task automatic drive(input bit val, input int no, input int prod, input int sc,
                        input bit rdy, input bit clr);
      bit pop, push, err;
      rd_val_i    = val;
      rd_data_i   = {no[7:0], prod[23:0]};
      scaler_i    = sc[SW-1:0];
      out_ready_i = rdy;
      clr_err_i   = clr;
      pop  = (m_cnt > 0) && rdy;
      push = val && ((m_cnt < DEPTH) || pop);
      if (push) exp_q.push_back({no[7:0], prod[23:0], sc[SW-1:0]});
      m_cnt = m_cnt + int'(push) - int'(pop);
      if (clr) begin
         m_ovf = 0; m_serr = 0; m_errs = 0; m_track = 0;
      end else if (val) begin
         if (!push) m_ovf = 1;
         err = (m_track && (no != m_exp)) || (prod > 255 * sc);
         if (err) begin
            m_serr = 1;
            if (m_errs < 255) m_errs++;
         end
         m_exp   = (no + 1) % 256;
         m_track = 1;
      end
      @(posedge clk_i);
      #1;
      chk_status();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 1, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_count"}, count_o, 0);
      chk({tag, "_empty"}, empty_o, 1);
      chk({tag, "_full"}, full_o, 0);
      chk({tag, "_valid"}, out_valid_o, 0);
      chk({tag, "_no"}, out_no_o, 0);
      chk({tag, "_result"}, out_result_o, 0);
      chk({tag, "_scaler"}, out_scaler_o, 0);
      chk({tag, "_ovf"}, overflow_o, 0);
      chk({tag, "_serr"}, seq_err_o, 0);
      chk({tag, "_errcnt"}, err_cnt_o, 0);
      chk({tag, "_state"}, chk_state_o, 0);
   endtask

   // Monitor: every DUT pop must match the oldest expected entry
   always @(negedge clk_i) begin
      logic [EW-1:0] e;
      if (!rst_i && out_valid_o && out_ready_i) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL pop_unexpected: got no=%0d expected none", out_no_o);
         end else begin
            e = exp_q.pop_front();
            chk("head_no", out_no_o, e[EW-1 -: 8]);
            chk("head_result", out_result_o, e[SW +: 24]);
            chk("head_scaler", out_scaler_o, e[SW-1:0]);
         end
      end
   end

   initial begin
      int rn, sc, lim, prod;
      repeat (2) @(posedge clk_i);
      #1;
      check_reset_outputs("init");
      @(negedge clk_i);
      rst_i = 1'b0;
      @(posedge clk_i);
      #1;

      // In-order delivery with matching sequence numbers
      drive(1, 5, 2500, 100, 1, 0);
      drive(1, 6, 3000, 100, 1, 0);
      idle(3);
      chk("basic_seq_err", seq_err_o, 0);

      // Fill with no backpressure release; fifth sample dropped
      drive(0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 5; i++) drive(1, i, 10, 1, 0, 0);
      chk("fill_count", count_o, 4);
      chk("fill_ovf", overflow_o, 1);
      chk("fill_errcnt", err_cnt_o, 0);

      // Full FIFO with simultaneous push and pop
      drive(0, 0, 0, 0, 0, 1);
      drive(1, 5, 10, 1, 1, 0);
      chk("fullpp_count", count_o, 4);
      chk("fullpp_ovf", overflow_o, 0);
      idle(5);

      // Sequence wrap is legal, gap is flagged once, resync follows
      drive(0, 0, 0, 0, 1, 1);
      drive(1, 254, 1, 1, 1, 0);
      drive(1, 255, 1, 1, 1, 0);
      drive(1, 0, 1, 1, 1, 0);
      drive(1, 1, 1, 1, 1, 0);
      chk("wrap_serr", seq_err_o, 0);
      drive(1, 3, 1, 1, 1, 0);
      chk("gap_errcnt", err_cnt_o, 1);
      drive(1, 4, 1, 1, 1, 0);
      chk("resync_errcnt", err_cnt_o, 1);

      // Range boundary and saturation, then clear
      drive(0, 0, 0, 0, 1, 1);
      drive(1, 10, 510, 2, 1, 0);
      chk("range_edge_ok", err_cnt_o, 0);
      drive(1, 11, 511, 2, 1, 0);
      chk("range_err", err_cnt_o, 1);
      for (int i = 0; i < 300; i++) drive(1, (12 + i) % 256, 1000, 2, 1, 0);
      chk("sat_errcnt", err_cnt_o, 255);
      drive(0, 0, 0, 0, 1, 1);
      chk("clr_state", chk_state_o, 0);
      idle(5);

      // Asynchronous reset between edges with entries buffered
      drive(1, 20, 5, 1, 0, 0);
      drive(1, 21, 5, 1, 0, 0);
      rd_val_i = 1'b1;
      rst_i    = 1'b1;
      #2;
      exp_q.delete();
      m_cnt = 0; m_track = 0; m_exp = 0; m_errs = 0; m_ovf = 0; m_serr = 0;
      check_reset_outputs("async_rst");
      @(posedge clk_i);
      #1;
      check_reset_outputs("rst_hold");
      @(negedge clk_i);
      #1;
      rst_i    = 1'b0;
      rd_val_i = 1'b0;
      @(posedge clk_i);
      #1;
      drive(1, 9, 100, 1, 1, 0);
      chk("post_rst_err", seq_err_o, 0);
      idle(3);

      // Randomized traffic
      rn = 0;
      for (int i = 0; i < 600; i++) begin
         rn  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : (rn + 1) % 256;
         sc  = $urandom_range(0, 5);
         lim = 255 * sc;
         case ($urandom_range(0, 2))
            0:       prod = int'($urandom_range(0, lim));
            1:       prod = (lim == 0) ? int'($urandom_range(0, 1)) : lim + int'($urandom_range(0, 2)) - 1;
            default: prod = int'($urandom_range(0, 24'hFFFFFF));
         endcase
         drive($urandom_range(0, 3) != 0, rn, prod, sc,
               $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
      end
      idle(DEPTH + 4);
      chk("drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
